// File: rtl/rf_req_pkg.sv
// rtl/rf_req_pkg.sv - shared types and constants for the register-file requester
package rf_req_pkg;

  localparam int DEF_DW = 8;
  localparam int DEF_AW = 3;
  localparam logic [7:0] ERRCNT_MAX = 8'd255;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE_WR = 3'd1,
    ISSUE_RD = 3'd2,
    CAPTURE  = 3'd3,
    RESP     = 3'd4
  } state_t;

  typedef enum logic {
    GNT_WR = 1'b0,
    GNT_RD = 1'b1
  } grant_t;

endpackage

// File: rtl/rf_requester_if.sv
// rtl/rf_requester_if.sv - client-side write/read request and read response channels
interface rf_requester_if import rf_req_pkg::*; #(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
);
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [AW-1:0] rd_addr;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;

  modport master (
    output wr_valid, wr_addr, wr_data, rd_valid, rd_addr, rsp_ready,
    input  wr_ready, rd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr, rsp_ready,
    output wr_ready, rd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/rf_req_arb.sv
// rtl/rf_req_arb.sv - 2-way round-robin arbiter between write and read requests
module rf_req_arb import rf_req_pkg::*; (
  input  logic   clk,
  input  logic   resetn,
  input  logic   wr_valid,
  input  logic   rd_valid,
  input  logic   accept,
  output grant_t gnt
);
  grant_t last;

  // A contested request goes to whichever side lost the previous accepted grant.
  always_comb begin
    gnt = (last == GNT_RD) ? GNT_WR : GNT_RD;
    if (wr_valid && !rd_valid)
      gnt = GNT_WR;
    else if (rd_valid && !wr_valid)
      gnt = GNT_RD;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      last <= GNT_RD;
    else if (accept)
      last <= gnt;
  end
endmodule

// File: rtl/rf_requester.sv
// rtl/rf_requester.sv - single-outstanding register-file requester; RF_REQ_ERRCNT_EN adds err_count
module rf_requester import rf_req_pkg::*; #(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          resetn,
  rf_requester_if.slave bus,
  output logic          rf_wr,
  output logic          rf_rd,
  output logic [AW-1:0] rf_addr,
  output logic [DW-1:0] rf_din,
  input  logic [DW-1:0] rf_dout,
  input  logic          rf_error
`ifdef RF_REQ_ERRCNT_EN
  ,
  output logic [7:0]    err_count
`endif
);
  state_t state, state_nx;
  grant_t gnt;
  logic   wr_acc, rd_acc;

  rf_req_arb u_arb (
    .clk      (clk),
    .resetn   (resetn),
    .wr_valid (bus.wr_valid),
    .rd_valid (bus.rd_valid),
    .accept   (wr_acc | rd_acc),
    .gnt      (gnt)
  );

  // Accepts are derived from state and grant so they never loop through the ready outputs.
  assign wr_acc = (state == IDLE) && (gnt == GNT_WR) && bus.wr_valid;
  assign rd_acc = (state == IDLE) && (gnt == GNT_RD) && bus.rd_valid;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    bus.wr_ready  = 1'b0;
    bus.rd_ready  = 1'b0;
    bus.rsp_valid = 1'b0;
    rf_wr         = 1'b0;
    rf_rd         = 1'b0;
    case (state)
      IDLE: begin
        bus.wr_ready = (gnt == GNT_WR);
        bus.rd_ready = (gnt == GNT_RD);
        if (wr_acc)
          state_nx = ISSUE_WR;
        else if (rd_acc)
          state_nx = ISSUE_RD;
      end
      ISSUE_WR: begin
        rf_wr    = 1'b1;
        state_nx = IDLE;
      end
      ISSUE_RD: begin
        rf_rd    = 1'b1;
        state_nx = CAPTURE;
      end
      CAPTURE: state_nx = RESP;
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rf_addr <= '0;
      rf_din  <= '0;
    end else if (wr_acc) begin
      rf_addr <= bus.wr_addr;
      rf_din  <= bus.wr_data;
    end else if (rd_acc) begin
      rf_addr <= bus.rd_addr;
    end
  end

  // Errored reads return zero data so a client never consumes garbage.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.rsp_data <= '0;
      bus.rsp_err  <= 1'b0;
    end else if (state == CAPTURE) begin
      bus.rsp_err  <= rf_error;
      bus.rsp_data <= rf_error ? '0 : rf_dout;
    end
  end

`ifdef RF_REQ_ERRCNT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      err_count <= '0;
    else if (rf_error && (err_count != ERRCNT_MAX))
      err_count <= err_count + 8'd1;
  end
`endif
endmodule
